window_serializer: RTL and testbench

// Parametrised successor to the 9-way tap selector in the CNN datapath. Captures a

---
 rtl/window_serializer.sv | 85 ++++++++
 tb/tb_window_serializer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/window_serializer.sv
// window_serializer: captures a full KxK tap window in one load and streams it one tap per cycle
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   window present on in_data
//   in_ready   window is captured this cycle
//   in_data    tap k at bits [k*DATA_W +: DATA_W]
//   in_desc    0 = tap 0 first, 1 = tap N_TAPS-1 first
//   out_valid  out_data/out_idx/out_last are valid
//   out_ready  consumer accepts current tap
//   out_data   current tap value (0 when out_valid=0)
//   out_idx    index of current tap within the window
//   out_last   current tap is the final tap of the window
//   busy       window held (STREAM)
module window_serializer #(
    parameter int DATA_W = 8,
    parameter int N_TAPS = 9,
    parameter int IDX_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_TAPS*DATA_W-1:0] in_data,
    input  logic                     in_desc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_last,
    output logic                     busy
);
    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TAPS - 1);

    state_t                   r_state;
    logic [N_TAPS*DATA_W-1:0] r_win;
    logic                     r_desc;
    logic [IDX_W-1:0]         r_idx;
    logic [DATA_W-1:0]        w_taps [2**IDX_W];
    logic                     w_load;
    logic                     w_xfer;

    // Unreachable indices map to zero taps so the mux is total.
    for (genvar k = 0; k < 2**IDX_W; k++) begin : g_tap
        if (k < N_TAPS) begin : g_real
            assign w_taps[k] = r_win[k*DATA_W +: DATA_W];
        end else begin : g_pad
            assign w_taps[k] = '0;
        end
    end

    assign busy      = (r_state == STREAM);
    assign out_valid = busy;
    assign out_idx   = r_idx;
    assign out_last  = busy & (r_desc ? (r_idx == '0) : (r_idx == LAST_IDX));
    assign out_data  = busy ? w_taps[r_idx] : '0;
    // Accepting during the final transfer keeps the stream bubble-free.
    assign in_ready  = !busy | (out_valid & out_ready & out_last);
    assign w_load    = in_valid & in_ready;
    assign w_xfer    = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_win   <= '0;
            r_desc  <= 1'b0;
            r_idx   <= '0;
        end else if (w_load) begin
            r_state <= STREAM;
            r_win   <= in_data;
            r_desc  <= in_desc;
            r_idx   <= in_desc ? LAST_IDX : '0;
        end else if (w_xfer) begin
            if (out_last) begin
                r_state <= IDLE;
                r_idx   <= '0;
            end else begin
                r_idx <= r_desc ? r_idx - 1'b1 : r_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_window_serializer.sv
// tb_window_serializer: random and directed stimulus checked against a tap-queue reference model
module tb_window_serializer;
    localparam int DATA_W = 8;
    localparam int N_TAPS = 9;
    localparam int IDX_W  = 4;
    localparam int WIN_W  = N_TAPS * DATA_W;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [IDX_W-1:0]  idx;
        logic              last;
    } tap_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIN_W-1:0]  in_data = '0;
    logic              in_desc = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
    logic              busy;

    int   n_checks = 0;
    int   n_errors = 0;
    tap_t exp_q[$];

    window_serializer #(.DATA_W(DATA_W), .N_TAPS(N_TAPS), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_desc(in_desc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIN_W-1:0] ramp(input int base);
        logic [WIN_W-1:0] w = '0;
        for (int k = 0; k < N_TAPS; k++) w[k*DATA_W +: DATA_W] = DATA_W'(base + k);
        return w;
    endfunction

    // One clock cycle: drive, compare against the model, then advance the model on the edge.
    task automatic step(input logic iv, input logic [WIN_W-1:0] d, input logic ds, input logic ordy);
        logic exp_rdy, fire_in, fire_out;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        in_desc   = ds;
        out_ready = ordy;
        #1;
        exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && ordy);
        check("out_valid", out_valid, exp_q.size() > 0);
        check("busy", busy, exp_q.size() > 0);
        check("in_ready", in_ready, exp_rdy);
        if (exp_q.size() > 0) begin
            check("out_data", out_data, exp_q[0].d);
            check("out_idx", out_idx, exp_q[0].idx);
            check("out_last", out_last, exp_q[0].last);
        end else begin
            check("idle_data", out_data, 0);
            check("idle_last", out_last, 0);
        end
        fire_in  = iv && exp_rdy;
        fire_out = (exp_q.size() > 0) && ordy;
        @(posedge clk);
        if (fire_out) void'(exp_q.pop_front());
        if (fire_in)
            for (int j = 0; j < N_TAPS; j++) begin
                int k = ds ? N_TAPS - 1 - j : j;
                exp_q.push_back('{d[k*DATA_W +: DATA_W], IDX_W'(k), j == N_TAPS - 1});
            end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_idx", out_idx, 0);
        check("rst_data", out_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Ascending window, then back-to-back 0xA0 window offered during the last tap.
        step(1'b1, ramp('h10), 1'b0, 1'b1);
        drain(N_TAPS - 1);
        step(1'b1, ramp('hA0), 1'b0, 1'b1);
        drain(N_TAPS + 1);

        // Descending window.
        step(1'b1, ramp('h10), 1'b1, 1'b1);
        drain(N_TAPS + 1);

        // Ignored load at idx 3, stall three cycles at idx 4.
        step(1'b1, ramp('h10), 1'b0, 1'b1);
        drain(3);
        step(1'b1, '1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
        drain(6);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            logic [WIN_W-1:0] d;
            for (int k = 0; k < N_TAPS; k++) d[k*DATA_W +: DATA_W] = DATA_W'($urandom);
            step(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        end
        drain(2 * N_TAPS);

        // Asynchronous reset mid-stream.
        step(1'b1, ramp('h40), 1'b0, 1'b1);
        drain(3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_data", out_data, 0);
        check("abort_last", out_last, 0);
        check("abort_idx", out_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_in_ready", in_ready, 1);
        step(1'b1, ramp('h60), 1'b1, 1'b1);
        drain(N_TAPS + 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
